// File: rtl/pc_ctrl_pkg.sv
// Shared types and helpers for the fetch PC controller and its branch target buffer.
// Counter encodings, saturating counter steps, and the BTB entry layout for the default geometry.
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_t;

  localparam int unsigned PC_XLEN      = 32;
  localparam int unsigned PC_BTB_DEPTH = 16;
  localparam int unsigned PC_BTB_IDX   = $clog2(PC_BTB_DEPTH);
  localparam int unsigned PC_BTB_TAG_W = PC_XLEN - PC_BTB_IDX - 2;

  typedef struct packed {
    logic                    valid;
    logic [PC_BTB_TAG_W-1:0] tag;
    logic [PC_XLEN-1:0]      target;
    ctr_t                    ctr;
  } btb_entry_t;

  function automatic ctr_t ctr_inc(input ctr_t c);
    unique case (c)
      CTR_SNT: return CTR_WNT;
      CTR_WNT: return CTR_WT;
      default: return CTR_ST;
    endcase
  endfunction

  function automatic ctr_t ctr_dec(input ctr_t c);
    unique case (c)
      CTR_ST:  return CTR_WT;
      CTR_WT:  return CTR_WNT;
      default: return CTR_SNT;
    endcase
  endfunction

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Lookup is combinational on lookup_pc; training from EX is written on the rising edge.
module pc_btb
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            hit_taken,
  output logic [XLEN-1:0] hit_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_taken
);

  localparam int unsigned IDX   = $clog2(DEPTH);
  localparam int unsigned TAG_W = XLEN - IDX - 2;

  // Same layout as btb_entry_t, but sized from this instance's parameters.
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
    ctr_t             ctr;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           rd_e;
  entry_t           wr_e;
  logic [IDX-1:0]   rd_idx;
  logic [IDX-1:0]   wr_idx;
  logic [TAG_W-1:0] rd_tag;
  logic [TAG_W-1:0] wr_tag;
  logic             wr_hit;
  logic             unused_lsbs;

  assign rd_idx = lookup_pc[IDX+1:2];
  assign rd_tag = lookup_pc[XLEN-1:IDX+2];
  assign wr_idx = upd_pc[IDX+1:2];
  assign wr_tag = upd_pc[XLEN-1:IDX+2];
  assign unused_lsbs = ^{lookup_pc[1:0], upd_pc[1:0]};

  assign rd_e       = mem[rd_idx];
  assign wr_e       = mem[wr_idx];
  assign hit_taken  = rd_e.valid && (rd_e.tag == rd_tag) && rd_e.ctr[1];
  assign hit_target = rd_e.target;
  assign wr_hit     = wr_e.valid && (wr_e.tag == wr_tag);

  // A write to the index being looked up only shows on the next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (upd_valid) begin
      if (wr_hit) begin
        if (upd_taken) begin
          mem[wr_idx].ctr    <= ctr_inc(wr_e.ctr);
          mem[wr_idx].target <= upd_target;
        end else begin
          mem[wr_idx].ctr <= ctr_dec(wr_e.ctr);
        end
      end else if (upd_taken) begin
        mem[wr_idx] <= '{valid: 1'b1, tag: wr_tag, target: upd_target, ctr: CTR_WT};
      end
    end
  end

endmodule

// File: rtl/pc_ctrl_predict.sv
// Fetch PC register with next-PC priority mux: redirect, stall, jump, prediction, sequential.
// The BTB predictor exists only when BTB_EN is defined; otherwise prediction is off and upd_* is ignored.
module pc_ctrl_predict
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int unsigned     BTB_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hazard,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_taken,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target
);

  logic [XLEN-1:0] next_pc;

  assign pc_plus4 = pc + XLEN'(4);

`ifdef BTB_EN
  logic            btb_hit;
  logic [XLEN-1:0] btb_target;

  pc_btb #(
    .XLEN  (XLEN),
    .DEPTH (BTB_DEPTH)
  ) u_btb (
    .clk        (clk),
    .rst        (rst),
    .lookup_pc  (pc),
    .hit_taken  (btb_hit),
    .hit_target (btb_target),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_target (upd_target),
    .upd_taken  (upd_taken)
  );

  assign pred_taken  = btb_hit;
  assign pred_target = btb_hit ? btb_target : pc_plus4;
`else
  logic unused_upd;

  assign unused_upd  = ^{upd_valid, upd_pc, upd_target, upd_taken};
  assign pred_taken  = 1'b0;
  assign pred_target = pc_plus4;
`endif

  // A stalled jump is dropped, not queued; ID presents it again after the stall.
  always_comb begin
    next_pc = pc_plus4;
    if (redirect_valid) begin
      next_pc = redirect_pc;
    end else if (hazard) begin
      next_pc = pc;
    end else if (jump) begin
      next_pc = jump_target;
    end else if (pred_taken) begin
      next_pc = pred_target;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= {RESET_VEC[XLEN-1:2], 2'b00};
    end else begin
      pc <= {next_pc[XLEN-1:2], 2'b00};
    end
  end

endmodule

// File: tb/tb_pc_ctrl_predict.sv
// Directed and random stimulus for pc_ctrl_predict against a behavioural fetch/BTB model.
module tb_pc_ctrl_predict;

  localparam int DEPTH = 16;
  localparam int IDX   = 4;
`ifdef BTB_EN
  localparam bit BTB_ON = 1'b1;
`else
  localparam bit BTB_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        hazard, redirect_valid, jump, upd_valid, upd_taken;
  logic [31:0] redirect_pc, jump_target, upd_pc, upd_target;
  logic [31:0] pc, pc_plus4, pred_target;
  logic        pred_taken;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pc_ctrl_predict #(
    .XLEN      (32),
    .RESET_VEC (32'h0),
    .BTB_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .hazard         (hazard),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .jump           (jump),
    .jump_target    (jump_target),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_target     (upd_target),
    .upd_taken      (upd_taken),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target)
  );

  // Reference model: fetch PC plus a table of BTB entries held as plain integers.
  logic [31:0] m_pc;
  bit          m_valid  [DEPTH];
  logic [31:0] m_tag    [DEPTH];
  logic [31:0] m_target [DEPTH];
  int          m_ctr    [DEPTH];

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] a);
    return a >> (IDX + 2);
  endfunction

  function automatic bit m_pred();
    int i;
    if (!BTB_ON) return 1'b0;
    i = idx_of(m_pc);
    return m_valid[i] && (m_tag[i] == tag_of(m_pc)) && (m_ctr[i] >= 2);
  endfunction

  function automatic logic [31:0] m_ptarget();
    if (m_pred()) return m_target[idx_of(m_pc)];
    return m_pc + 32'd4;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0;
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic set_ctl(input bit rv, input logic [31:0] rpc, input bit hz,
                         input bit j, input logic [31:0] jt);
    redirect_valid = rv;
    redirect_pc    = rpc;
    hazard         = hz;
    jump           = j;
    jump_target    = jt;
  endtask

  task automatic set_upd(input bit v, input logic [31:0] p, input logic [31:0] t, input bit tk);
    upd_valid  = v;
    upd_pc     = p;
    upd_target = t;
    upd_taken  = tk;
  endtask

  // Check outputs for the current pc, predict the next one, then cross one rising edge.
  task automatic cycle();
    logic [31:0] nxt;
    int          i;
    logic [31:0] t;
    bit          hit;
    check("pc", pc, m_pc);
    check("pc_plus4", pc_plus4, m_pc + 32'd4);
    check("pred_taken", 32'(pred_taken), 32'(m_pred()));
    check("pred_target", pred_target, m_ptarget());
    if (redirect_valid)  nxt = redirect_pc;
    else if (hazard)     nxt = m_pc;
    else if (jump)       nxt = jump_target;
    else if (m_pred())   nxt = m_ptarget();
    else                 nxt = m_pc + 32'd4;
    nxt = nxt & 32'hFFFF_FFFC;
    if (BTB_ON && upd_valid) begin
      i   = idx_of(upd_pc);
      t   = tag_of(upd_pc);
      hit = m_valid[i] && (m_tag[i] == t);
      if (hit && upd_taken) begin
        m_ctr[i]    = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
        m_target[i] = upd_target;
      end else if (hit) begin
        m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
      end else if (upd_taken) begin
        m_valid[i]  = 1'b1;
        m_tag[i]    = t;
        m_target[i] = upd_target;
        m_ctr[i]    = 2;
      end
    end
    @(posedge clk);
    #1;
    m_pc = nxt;
  endtask

  initial begin
    rst = 1'b1;
    set_ctl(0, 32'h0, 0, 0, 32'h0);
    set_upd(0, 32'h0, 32'h0, 0);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("reset_pc", pc, 32'h0);
    check("reset_pred_taken", 32'(pred_taken), 32'h0);
    check("reset_pred_target", pred_target, 32'h4);
    @(posedge clk);
    #1;
    check("reset_hold_pc", pc, 32'h0);
    rst = 1'b1;

    // Sequential fetch from reset: 0, 4, 8, C, then stall at 0x10.
    repeat (4) cycle();
    set_ctl(0, 32'h0, 1, 0, 32'h0);
    repeat (3) cycle();
    set_ctl(0, 32'h0, 0, 0, 32'h0);
    cycle();
    check("stall_release_pc", pc, 32'h14);

    // Redirect beats hazard and jump; a stalled jump is dropped.
    set_ctl(1, 32'h200, 1, 1, 32'h100);
    cycle();
    check("prio_redirect_pc", pc, 32'h200);
    set_ctl(0, 32'h0, 1, 1, 32'h100);
    cycle();
    check("prio_hazard_jump_pc", pc, 32'h200);

    // Reset mid-stall and mid-redirect acts without a clock edge.
    set_ctl(1, 32'h300, 1, 0, 32'h0);
    rst = 1'b0;
    #2;
    model_reset();
    check("async_reset_pc", pc, 32'h0);
    set_ctl(0, 32'h0, 0, 0, 32'h0);
    @(posedge clk);
    #1;
    check("async_reset_hold_pc", pc, 32'h0);
    rst = 1'b1;
    repeat (2) cycle();

    // Masking of low bits and wrap of the sequential increment.
    set_ctl(1, 32'hFFFF_FFFE, 0, 0, 32'h0);
    cycle();
    set_ctl(0, 32'h0, 0, 0, 32'h0);
    check("wrap_mask_pc", pc, 32'hFFFF_FFFC);
    check("wrap_plus4", pc_plus4, 32'h0);
    cycle();
    check("wrap_pc", pc, 32'h0);

    // Train 0x40 taken to 0x80 and fetch into it.
    set_ctl(1, 32'h38, 0, 0, 32'h0);
    set_upd(1, 32'h40, 32'h80, 1);
    cycle();
    set_ctl(0, 32'h0, 0, 0, 32'h0);
    set_upd(0, 32'h0, 32'h0, 0);
    repeat (2) cycle();
    check("btb_at40_pc", pc, 32'h40);
`ifdef BTB_EN
    check("btb_pred_taken", 32'(pred_taken), 32'h1);
    check("btb_pred_target", pred_target, 32'h80);
`else
    check("nobtb_pred_taken", 32'(pred_taken), 32'h0);
    check("nobtb_pred_target", pred_target, 32'h44);
`endif
    cycle();
    check("btb_follow_pc", pc, BTB_ON ? 32'h80 : 32'h44);

    // Two not-taken updates walk the counter down to strong-NT.
    set_ctl(1, 32'h40, 0, 0, 32'h0);
    set_upd(1, 32'h40, 32'h0, 0);
    cycle();
    set_ctl(0, 32'h0, 0, 0, 32'h0);
    check("btb_weak_nt_pred", 32'(pred_taken), 32'h0);
    cycle();
    set_upd(0, 32'h0, 32'h0, 0);
    check("btb_strong_nt_pc", pc, 32'h44);

    // Aliasing: 0x440 shares the index of 0x40 with a different tag.
    set_upd(1, 32'h40, 32'h80, 1);
    cycle();
    set_upd(1, 32'h440, 32'h900, 1);
    cycle();
    set_upd(0, 32'h0, 32'h0, 0);
    set_ctl(1, 32'h40, 0, 0, 32'h0);
    cycle();
    set_ctl(0, 32'h0, 0, 0, 32'h0);
    check("alias_old_tag_pred", 32'(pred_taken), 32'h0);
    set_ctl(1, 32'h440, 0, 0, 32'h0);
    cycle();
    set_ctl(0, 32'h0, 0, 0, 32'h0);
    check("alias_new_pred_taken", 32'(pred_taken), BTB_ON ? 32'h1 : 32'h0);
    check("alias_new_pred_target", pred_target, BTB_ON ? 32'h900 : 32'h444);

    // Training the entry being looked up: the lookup still sees the old contents.
    set_upd(1, 32'h440, 32'h0, 0);
    cycle();
    set_upd(0, 32'h0, 32'h0, 0);
    check("same_cycle_pc", pc, BTB_ON ? 32'h900 : 32'h444);
    cycle();

    // Random traffic kept mostly within a small window so BTB entries get reused.
    for (int n = 0; n < 400; n++) begin
      set_ctl($urandom_range(0, 9) == 0,
              ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 511)),
              $urandom_range(0, 3) == 0,
              $urandom_range(0, 6) == 0,
              32'($urandom_range(0, 511)));
      set_upd($urandom_range(0, 4) < 2,
              32'($urandom_range(0, 127) << 2) | (($urandom_range(0, 5) == 0) ? 32'h400 : 32'h0),
              32'($urandom_range(0, 511)),
              $urandom_range(0, 2) != 0);
      cycle();
    end
    set_ctl(0, 32'h0, 0, 0, 32'h0);
    set_upd(0, 32'h0, 32'h0, 0);
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
